// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative RV32M multiply/divide unit.
package muldiv_pkg;

  localparam int XLEN          = 32;
  localparam int MULDIV_CYCLES = XLEN;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } muldiv_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } muldiv_state_e;

endpackage

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: one product or quotient bit per cycle over
// a shared hi/lo shift register pair, with sign correction on completion.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int DATA_WIDTH = XLEN
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [2:0]            funct3,
  input  logic [DATA_WIDTH-1:0] op_a,
  input  logic [DATA_WIDTH-1:0] op_b,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] result
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W);

  muldiv_state_e state_q;
  muldiv_op_e    op_q;
  logic [CW-1:0] cnt_q;
  logic [W-1:0]  hi_q, lo_q, divisor_q;
  logic          neg_q, sign_a_q;
  logic          busy_q, done_q;
  logic [W-1:0]  result_q;

  // Accept-time decode of the incoming request
  muldiv_op_e   op_in;
  logic         a_signed, b_signed, sa, sb;
  logic [W-1:0] a_mag, b_mag;
  logic         is_div, div_zero, div_ovf, special;
  logic [W-1:0] special_res;

  assign op_in = muldiv_op_e'(funct3);

  always_comb begin
    a_signed = 1'b0;
    b_signed = 1'b0;
    case (op_in)
      OP_MULH, OP_DIV, OP_REM: begin
        a_signed = 1'b1;
        b_signed = 1'b1;
      end
      OP_MULHSU: a_signed = 1'b1;
      default: ;
    endcase
  end

  assign sa          = a_signed & op_a[W-1];
  assign sb          = b_signed & op_b[W-1];
  assign a_mag       = sa ? -op_a : op_a;
  assign b_mag       = sb ? -op_b : op_b;
  assign is_div      = funct3[2];
  assign div_zero    = is_div && (op_b == '0);
  assign div_ovf     = is_div && !funct3[0] && (op_a == {1'b1, {(W-1){1'b0}}}) && (op_b == '1);
  assign special     = div_zero || div_ovf;
  // funct3[1] selects the remainder flavour within the divide group
  assign special_res = div_zero ? (funct3[1] ? op_a : '1)
                                : (funct3[1] ? '0 : {1'b1, {(W-1){1'b0}}});

  // One iteration of shift-add multiply or restoring divide
  logic [W:0]   add_sum, rem_shift, rem_diff;
  logic         rem_ge;
  logic [W-1:0] hi_d, lo_d;

  assign add_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, divisor_q} : '0);
  assign rem_shift = {hi_q, lo_q[W-1]};
  assign rem_diff  = rem_shift - {1'b0, divisor_q};
  assign rem_ge    = !rem_diff[W];

  always_comb begin
    if (op_q[2]) begin
      hi_d = rem_ge ? rem_diff[W-1:0] : rem_shift[W-1:0];
      lo_d = {lo_q[W-2:0], rem_ge};
    end else begin
      hi_d = add_sum[W:1];
      lo_d = {add_sum[0], lo_q[W-1:1]};
    end
  end

  // Sign correction applied to the last iteration's output
  logic [2*W-1:0] prod, prod_fix;
  logic [W-1:0]   quo_fix, rem_fix, final_res;

  assign prod     = {hi_d, lo_d};
  assign prod_fix = neg_q ? -prod : prod;
  assign quo_fix  = neg_q ? -lo_d : lo_d;
  assign rem_fix  = sign_a_q ? -hi_d : hi_d;

  always_comb begin
    case (op_q)
      OP_MUL:                       final_res = prod_fix[W-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: final_res = prod_fix[2*W-1:W];
      OP_DIV, OP_DIVU:              final_res = quo_fix;
      default:                      final_res = rem_fix;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      op_q      <= OP_MUL;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      divisor_q <= '0;
      neg_q     <= 1'b0;
      sign_a_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      result_q  <= '0;
    end else begin
      case (state_q)
        ST_RUN: begin
          hi_q <= hi_d;
          lo_q <= lo_d;
          if (cnt_q == '0) begin
            state_q  <= ST_DONE;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            result_q <= final_res;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          done_q  <= 1'b0;
          if (start) begin
            op_q      <= op_in;
            neg_q     <= sa ^ sb;
            sign_a_q  <= sa;
            hi_q      <= '0;
            lo_q      <= is_div ? a_mag : b_mag;
            divisor_q <= is_div ? b_mag : a_mag;
            if (special) begin
              state_q  <= ST_DONE;
              done_q   <= 1'b1;
              result_q <= special_res;
            end else begin
              state_q <= ST_RUN;
              busy_q  <= 1'b1;
              cnt_q   <= CW'(W - 1);
            end
          end
        end
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: cycle-level timeline model plus directed literal vectors.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [2:0]  funct3;
  logic [31:0] op_a, op_b;
  logic        busy, done;
  logic [31:0] result;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  muldiv_unit #(.DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .funct3(funct3),
    .op_a(op_a), .op_b(op_b), .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Reference arithmetic straight from the RV32M definitions
  function automatic logic [31:0] model_res(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'h0, a});
    ub = longint'({32'h0, b});
    case (f)
      3'd0: begin p = 64'(ua * ub); return p[31:0]; end
      3'd1: begin p = 64'(sa * sb); return p[63:32]; end
      3'd2: begin p = 64'(sa * ub); return p[63:32]; end
      3'd3: begin p = 64'(ua * ub); return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        p = 64'(sa / sb); return p[31:0];
      end
      3'd5: begin
        if (b == 0) return 32'hFFFF_FFFF;
        p = 64'(ua / ub); return p[31:0];
      end
      3'd6: begin
        if (b == 0) return a;
        p = 64'(sa % sb); return p[31:0];
      end
      default: begin
        if (b == 0) return a;
        p = 64'(ua % ub); return p[31:0];
      end
    endcase
  endfunction

  function automatic bit model_special(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    return f[2] && (b == 0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
  endfunction

  // Timeline model: an accepted request completes at a known cycle
  int          cyc = 0;
  bit          m_pend = 1'b0;
  int          m_done_at = 0;
  logic [31:0] m_val = '0;
  logic        exp_busy = 1'b0, exp_done = 1'b0;
  logic [31:0] exp_res = '0;

  always @(posedge clk) begin
    if (rst) begin
      m_pend   = 1'b0;
      exp_busy = 1'b0;
      exp_done = 1'b0;
      exp_res  = '0;
    end else begin
      if (start && !(m_pend && cyc < m_done_at)) begin
        m_pend    = 1'b1;
        m_val     = model_res(funct3, op_a, op_b);
        m_done_at = cyc + (model_special(funct3, op_a, op_b) ? 1 : MULDIV_CYCLES + 1);
      end
      exp_busy = m_pend && (cyc + 1 < m_done_at);
      exp_done = m_pend && (cyc + 1 == m_done_at);
      if (exp_done) exp_res = m_val;
    end
    cyc++;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc_busy", 32'(busy), 32'(exp_busy));
      check("cyc_done", 32'(done), 32'(exp_done));
      check("cyc_result", result, exp_res);
      if (busy && done) check("busy_and_done", 32'(1), 32'(0));
    end
  end

  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; funct3 = f; op_a = a; op_b = b;
    @(negedge clk);
    start = 1'b0; funct3 = 3'($urandom); op_a = $urandom; op_b = $urandom;
  endtask

  task automatic wait_done(input int n0, output int n, output bit got);
    n = n0; got = 1'b0;
    while (!got && n <= 60) begin
      if (done) got = 1'b1;
      else begin
        @(negedge clk);
        n++;
      end
    end
  endtask

  task automatic do_op(input string name, input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, input int lat);
    int n; bit got;
    issue(f, a, b);
    wait_done(1, n, got);
    check({name, "_timeout"}, 32'(got), 32'(1));
    check({name, "_latency"}, 32'(n), 32'(lat));
    check({name, "_result"}, result, exp);
    $display("[TB] %s f=%0d a=%h b=%h -> %h after %0d cycles", name, f, a, b, result, n);
  endtask

  initial begin
    int n; bit got, seen;
    rst = 1'b1; start = 1'b0; funct3 = '0; op_a = '0; op_b = '0;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    check("reset_busy", 32'(busy), 32'(0));
    check("reset_done", 32'(done), 32'(0));
    check("reset_result", result, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    do_op("mul_7x6",      3'd0, 32'd7,          32'd6,          32'd42,         33);
    do_op("mulh_m1m1",    3'd1, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h0000_0000,  33);
    do_op("mulhu_m1m1",   3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE,  33);
    do_op("mulhsu_m1m1",  3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFF,  33);
    do_op("mulh_min_min", 3'd1, 32'h8000_0000,  32'h8000_0000,  32'h4000_0000,  33);
    do_op("mul_wrap",     3'd0, 32'hFFFF_FFFF,  32'd2,          32'hFFFF_FFFE,  33);
    do_op("div_m7_2",     3'd4, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  33);
    do_op("rem_m7_2",     3'd6, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  33);
    do_op("divu_m7_2",    3'd5, 32'hFFFF_FFF9,  32'd2,          32'h7FFF_FFFC,  33);
    do_op("remu_m7_2",    3'd7, 32'hFFFF_FFF9,  32'd2,          32'd1,          33);
    do_op("rem_7_m2",     3'd6, 32'd7,          32'hFFFF_FFFE,  32'd1,          33);
    do_op("div_by0",      3'd4, 32'd5,          32'd0,          32'hFFFF_FFFF,  1);
    do_op("remu_by0",     3'd7, 32'd5,          32'd0,          32'd5,          1);
    do_op("divu_by0",     3'd5, 32'd5,          32'd0,          32'hFFFF_FFFF,  1);
    do_op("div_ovf",      3'd4, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1);
    do_op("rem_ovf",      3'd6, 32'h8000_0000,  32'hFFFF_FFFF,  32'h0,          1);
    do_op("b2b_divu",     3'd5, 32'd100,        32'd7,          32'd14,         33);
    do_op("b2b_mul",      3'd0, 32'd3,          32'd5,          32'd15,         33);

    // A start pulsed mid-RUN must be ignored
    issue(3'd0, 32'd9, 32'd9);
    repeat (4) @(negedge clk);
    start = 1'b1; funct3 = 3'd5; op_a = 32'd100; op_b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    wait_done(6, n, got);
    check("midrun_timeout", 32'(got), 32'(1));
    check("midrun_latency", 32'(n), 32'(33));
    check("midrun_result", result, 32'd81);
    $display("[TB] midrun_start_ignored -> %h after %0d cycles", result, n);
    @(negedge clk);

    // Reset mid-RUN discards the operation
    issue(3'd0, 32'd7, 32'd6);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_busy", 32'(busy), 32'(0));
    check("midrst_done", 32'(done), 32'(0));
    check("midrst_result", result, 32'h0);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done || busy) seen = 1'b1;
    end
    check("midrst_no_done", 32'(seen), 32'(0));
    $display("[TB] reset_mid_run busy=%0d done=%0d result=%h", busy, done, result);

    // rst and start together: request dropped
    rst = 1'b1; start = 1'b1; funct3 = 3'd0; op_a = 32'd3; op_b = 32'd3;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done || busy) seen = 1'b1;
    end
    check("rst_start_dropped", 32'(seen), 32'(0));
    $display("[TB] rst_with_start busy_or_done_seen=%0d", seen);

    do_op("after_rst_mul", 3'd0, 32'd3, 32'd5, 32'd15, 33);
    @(negedge clk);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout at %0t", $time);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative RV32M multiply/divide unit for the CPU datapath. It consumes the two register-file read operands (RD1, RD2) and the instruction funct3. It produces a 32-bit result that the writeback mux returns to the register file write port (WD3). Control stalls the core while `busy` is high and enables the register write on `done`.

## Interface
Parameters:
- `DATA_WIDTH`, 32, operand/result width (XLEN); iteration count equals `DATA_WIDTH`.

Ports:
- `clk`  in  1  rising-edge clock; the single clock.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request pulse; sampled only in IDLE or DONE.
- `funct3`  in  3  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- `op_a`  in  DATA_WIDTH  rs1 value (from RD1).
- `op_b`  in  DATA_WIDTH  rs2 value (from RD2).
- `busy`  out  1  high while iterating.
- `done`  out  1  one-cycle pulse; `result` valid this cycle.
- `result`  out  DATA_WIDTH  registered result; held until the next accepted start.

## Operation
- Operands and funct3 are latched on the edge that accepts `start`. The inputs may change freely afterwards.
- States and transitions:
  - IDLE: `start` goes to RUN, or to DONE for a special case.
  - RUN: the counter decrements each cycle. When it reaches 0, the FSM goes to DONE.
  - DONE: `start` goes to RUN (or DONE for a special case); no start goes to IDLE.
- `start` is ignored while in RUN.
- Signed handling: operands are converted to magnitudes on accept, with a sign flag recorded per operand.
  - Signed operands: MULH (both), MULHSU (op_a only), DIV and REM (both).
  - The final result is negated in DONE entry according to the sign rules.
- Multiply: shift-add over a 2×DATA_WIDTH accumulator, one bit per cycle.
  - MUL returns the low half of the product.
  - MULH, MULHSU and MULHU return the high half of the sign-corrected 64-bit product.
- Divide: restoring division, one quotient bit per cycle.
  - The quotient sign is sign(a) XOR sign(b).
  - The remainder sign is sign(a).
- Special cases bypass RUN and go straight to DONE:
  - Divide by zero: DIV/DIVU return all-ones; REM/REMU return op_a.
  - Signed overflow (DIV/REM with op_a = 0x8000_0000 and op_b = 0xFFFF_FFFF): DIV returns 0x8000_0000; REM returns 0.
- All arithmetic is modulo 2^DATA_WIDTH. There are no exceptions or flags.

## Timing
- Reset values: state IDLE, `busy`=0, `done`=0, `result`=0, counter 0.
- Normal operation latency (start high in cycle N):
  - `busy`=1 in cycles N+1 … N+32.
  - `done`=1 and `result` valid in cycle N+33.
- Special-case latency: `done`=1 in cycle N+1, and `busy` stays 0.
- `busy` and `done` are never high together.
- `done` is exactly one cycle wide.
- Back-to-back: `start` in the DONE cycle is accepted. `result` updates only at the next `done`.
- A reset asserted in any state, including mid-RUN, forces the reset values on the next edge. The partial operation is discarded.
- `rst` and `start` asserted in the same cycle: `rst` wins, and the request is dropped.

## Structure
- Shared package `muldiv_pkg`:
  - funct3 enum `muldiv_op_e`.
  - FSM enum `muldiv_state_e` (IDLE, RUN, DONE).
  - Constant `MULDIV_CYCLES` = DATA_WIDTH.
- Single module holding the FSM, counter, accumulator/remainder registers and sign-correction logic.
- No sub-module is warranted: the multiply and divide datapaths share the shift registers and are selected by the latched op.

## Test plan
- MUL with op_a=7, op_b=6 → `busy` in cycles N+1..N+32; `done` in N+33 with `result`=42.
- MULH with op_a=0xFFFF_FFFF (−1), op_b=0xFFFF_FFFF → `result`=0x0000_0000. MULHU with the same operands → 0xFFFF_FFFE. MULHSU with the same operands → 0xFFFF_FFFF.
- Signed division with op_a=−7 (0xFFFF_FFF9), op_b=2:
  - DIV → 0xFFFF_FFFD (−3).
  - REM → 0xFFFF_FFFF (−1).
  - DIVU → 0x7FFF_FFFC.
- Special cases:
  - DIV with op_b=0 and op_a=5 → `done` in N+1 with 0xFFFF_FFFF.
  - REMU with op_b=0 and op_a=5 → 5.
  - DIV with op_a=0x8000_0000, op_b=0xFFFF_FFFF → 0x8000_0000 in N+1.
- Back-to-back: start DIVU 100/7, then start MUL 3×5 in the `done` cycle.
  - First `done` gives 14.
  - Second `done` arrives 33 cycles later with 15.
  - A `start` pulsed mid-RUN is ignored.
- Reset mid-RUN:
  - Assert `rst` in cycle N+10 → next cycle `busy`=0, `done`=0, `result`=0.
  - No `done` follows.
  - `rst` and `start` asserted together → no operation starts.
